// File: rtl/mem_pkg.sv
// Shared encodings for the RAM access initiator: request sizes, FSM states
// and the size/alignment legality helper.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Reserved size or an offset not aligned to the access size.
    function automatic logic size_align_error(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'd0);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// and load lane extraction with sign or zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_byteenable,
    output logic [31:0] st_wdata_rep,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_result
);

    logic [31:0] shift_s;

    // Store side: lane enables and data replicated across every lane.
    always_comb begin
        st_byteenable = 4'b0000;
        st_wdata_rep  = 32'h0000_0000;
        case (st_size)
            SIZE_BYTE: begin
                st_byteenable = 4'b0001 << st_off;
                st_wdata_rep  = {4{st_wdata[7:0]}};
            end
            SIZE_HALF: begin
                if (st_off[1]) begin
                    st_byteenable = 4'b1100;
                end else begin
                    st_byteenable = 4'b0011;
                end
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            SIZE_WORD: begin
                st_byteenable = 4'b1111;
                st_wdata_rep  = st_wdata;
            end
            default: begin
                st_byteenable = 4'b0000;
                st_wdata_rep  = 32'h0000_0000;
            end
        endcase
    end

    // Load side: word loads are always at offset 0, so the shifted word is the word itself.
    always_comb begin
        shift_s   = ld_rdata >> {ld_off, 3'b000};
        ld_result = 32'h0000_0000;
        case (ld_size)
            SIZE_BYTE: begin
                if (ld_unsigned) begin
                    ld_result = {24'h00_0000, shift_s[7:0]};
                end else begin
                    ld_result = {{24{shift_s[7]}}, shift_s[7:0]};
                end
            end
            SIZE_HALF: begin
                if (ld_unsigned) begin
                    ld_result = {16'h0000, shift_s[15:0]};
                end else begin
                    ld_result = {{16{shift_s[15]}}, shift_s[15:0]};
                end
            end
            SIZE_WORD: ld_result = shift_s;
            default:   ld_result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Load/store initiator for the single-cycle registered word RAM: accepts one
// byte-addressed request at a time and returns a one-cycle response pulse.
module mem_access
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'h0000_0000,
    parameter int          SIZE_WORDS = 65536
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] SIZE_W = 32'(SIZE_WORDS);

    state_t      state_r;
    state_t      next_state_s;
    logic        accept_s;
    logic        err_s;
    logic [31:0] word_idx_s;
    logic        write_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic [1:0]  off_r;
    logic [3:0]  st_be_s;
    logic [31:0] st_wdata_s;
    logic [31:0] ld_result_s;

    assign accept_s   = req_valid && req_ready;
    assign word_idx_s = (req_addr - BASE) >> 2'd2;
    assign err_s      = size_align_error(req_size, req_addr[1:0])
                        || (req_addr < BASE)
                        || (word_idx_s >= SIZE_W);

    mem_lane_align u_align (
        .st_size       (req_size),
        .st_off        (req_addr[1:0]),
        .st_wdata      (req_wdata),
        .st_byteenable (st_be_s),
        .st_wdata_rep  (st_wdata_s),
        .ld_size       (size_r),
        .ld_off        (off_r),
        .ld_unsigned   (unsigned_r),
        .ld_rdata      (mem_rdata),
        .ld_result     (ld_result_s)
    );

    // Next-state decode: errors skip the RAM, stores skip the read wait.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (err_s) begin
                        next_state_s = ST_RESP;
                    end else begin
                        next_state_s = ST_ISSUE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (write_r) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_WAIT: next_state_s = ST_RESP;
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State and output registers; pulses and response fields default low each cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_rdata     <= 32'h0000_0000;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= 32'h0000_0000;
            mem_byteenable <= 4'b0000;
            mem_wdata      <= 32'h0000_0000;
            write_r        <= 1'b0;
            size_r         <= SIZE_BYTE;
            unsigned_r     <= 1'b0;
            off_r          <= 2'd0;
        end else begin
            state_r    <= next_state_s;
            req_ready  <= (next_state_s == ST_IDLE);
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        write_r    <= req_write;
                        size_r     <= req_size;
                        unsigned_r <= req_unsigned;
                        off_r      <= req_addr[1:0];
                        if (err_s) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else begin
                            mem_read       <= !req_write;
                            mem_write      <= req_write;
                            mem_address    <= word_idx_s;
                            mem_byteenable <= st_be_s;
                            mem_wdata      <= st_wdata_s;
                        end
                    end else begin
                        write_r <= write_r;
                    end
                end
                ST_ISSUE: resp_valid <= write_r;
                ST_WAIT: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= ld_result_s;
                end
                ST_RESP: resp_valid <= 1'b0;
                default: resp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench: two mem_access instances (default map and a small window
// at 0x1000) each backed by a behavioural RAM; expectations are queued at issue.
module tb_mem_access;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_error;
    logic [31:0] resp_rdata [2];
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_address [2];
    logic [3:0]  mem_byteenable [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    logic [31:0] ram0 [64];
    logic [31:0] ram1 [16];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct { int dut; logic err; logic [31:0] rdata; int due; } resp_t;
    typedef struct { int dut; logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } strb_t;
    resp_t rq[$];
    strb_t sq[$];

    always #5 clock = ~clock;

    mem_access u_dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_error(resp_error[0]), .resp_rdata(resp_rdata[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_address(mem_address[0]),
        .mem_byteenable(mem_byteenable[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_access #(.BASE(32'h0000_1000), .SIZE_WORDS(16)) u_dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_error(resp_error[1]), .resp_rdata(resp_rdata[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_address(mem_address[1]),
        .mem_byteenable(mem_byteenable[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    // Cycle counter and behavioural RAMs with byte-enabled writes and registered reads.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_write[0]) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byteenable[0][b]) ram0[mem_address[0][5:0]][8*b +: 8] <= mem_wdata[0][8*b +: 8];
            end
        end
        if (mem_read[0]) mem_rdata[0] <= ram0[mem_address[0][5:0]];
        if (mem_write[1]) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byteenable[1][b]) ram1[mem_address[1][3:0]][8*b +: 8] <= mem_wdata[1][8*b +: 8];
            end
        end
        if (mem_read[1]) mem_rdata[1] <= ram1[mem_address[1][3:0]];
    end

    // Monitor: pop and compare on every response pulse and every RAM strobe.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (resp_valid[d] === 1'b1) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected dut%0d: err=%0b rdata=%h, none expected", d, resp_error[d], resp_rdata[d]);
                end else begin
                    resp_t e;
                    e = rq.pop_front();
                    if (e.dut != d || resp_error[d] !== e.err || resp_rdata[d] !== e.rdata || cyc != e.due) begin
                        errors++;
                        $display("FAIL resp dut%0d: got err=%0b rdata=%h cyc=%0d, expected dut%0d err=%0b rdata=%h cyc=%0d",
                                 d, resp_error[d], resp_rdata[d], cyc, e.dut, e.err, e.rdata, e.due);
                    end
                end
            end
            if (mem_read[d] === 1'b1 || mem_write[d] === 1'b1) begin
                checks++;
                if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected dut%0d: rd=%0b wr=%0b addr=%h, no strobe expected", d, mem_read[d], mem_write[d], mem_address[d]);
                end else begin
                    strb_t s;
                    s = sq.pop_front();
                    if (s.dut != d || mem_write[d] !== s.wr || mem_read[d] !== !s.wr || mem_address[d] !== s.addr
                        || mem_byteenable[d] !== s.be || (s.wr && mem_wdata[d] !== s.wdata)) begin
                        errors++;
                        $display("FAIL strobe dut%0d: got rd=%0b wr=%0b addr=%h be=%h wdata=%h, expected dut%0d wr=%0b addr=%h be=%h wdata=%h",
                                 d, mem_read[d], mem_write[d], mem_address[d], mem_byteenable[d], mem_wdata[d],
                                 s.dut, s.wr, s.addr, s.be, s.wdata);
                    end
                end
            end
        end
    end

    // Issue one request to dut d, queue its expectations, hold req_valid until the response cycle.
    task automatic do_req(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic err,
                          input logic [31:0] exp_rd, input logic [31:0] exp_ma,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int n;
        int lat;
        lat = err ? 1 : (wr ? 2 : 3);
        n = 0;
        @(negedge clock);
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout dut%0d: req_ready=%0b after %0d cycles, expected 1", d, req_ready[d], n);
            return;
        end
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid[d] = 1'b1;
        rq.push_back('{dut: d, err: err, rdata: exp_rd, due: cyc + lat});
        if (!err) sq.push_back('{dut: d, wr: wr, addr: exp_ma, be: exp_be, wdata: exp_wd});
        for (int k = 0; k < lat; k++) begin
            @(negedge clock);
            checks++;
            if (req_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready dut%0d: req_ready=%0b in busy cycle %0d, expected 0", d, req_ready[d], k);
            end
        end
        req_valid[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        req_write = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 || mem_read[d] !== 1'b0 || mem_write[d] !== 1'b0
                || mem_address[d] !== 32'h0 || resp_rdata[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: ready=%0b rv=%0b rd=%0b wr=%0b addr=%h rdata=%h, expected all 0",
                         d, req_ready[d], resp_valid[d], mem_read[d], mem_write[d], mem_address[d], resp_rdata[d]);
            end
        end
        reset = 1'b0;

        //     d  wr    sz    uns   addr          wdata         err   exp_rdata     ma     be       exp_wdata
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'd4, 4'b1111, 32'hDEAD_BEEF);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 32'd4, 4'b1111, 32'h0);
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'h80FF_7F01, 1'b0, 32'h0000_0000, 32'd0, 4'b1111, 32'h80FF_7F01);
        do_req(0, 1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0,         1'b0, 32'hFFFF_FF80, 32'd0, 4'b1000, 32'h0);
        do_req(0, 1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0,         1'b0, 32'h0000_0080, 32'd0, 4'b1000, 32'h0);
        do_req(0, 1'b0, 2'd0, 1'b0, 32'h0000_0001, 32'h0,         1'b0, 32'h0000_007F, 32'd0, 4'b0010, 32'h0);
        do_req(0, 1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'h0000_ABCD, 1'b0, 32'h0000_0000, 32'd1, 4'b1100, 32'hABCD_ABCD);
        do_req(0, 1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0,         1'b0, 32'hFFFF_ABCD, 32'd1, 4'b1100, 32'h0);
        do_req(0, 1'b0, 2'd1, 1'b1, 32'h0000_0006, 32'h0,         1'b0, 32'h0000_ABCD, 32'd1, 4'b1100, 32'h0);
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'h1122_3344, 1'b0, 32'h0000_0000, 32'd2, 4'b1111, 32'h1122_3344);
        do_req(0, 1'b1, 2'd0, 1'b0, 32'h0000_0009, 32'h0000_00A5, 1'b0, 32'h0000_0000, 32'd2, 4'b0010, 32'hA5A5_A5A5);
        do_req(0, 1'b0, 2'd2, 1'b1, 32'h0000_0008, 32'h0,         1'b0, 32'h1122_A544, 32'd2, 4'b1111, 32'h0);
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h0000_0002, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'd0, 4'b0000, 32'h0);
        do_req(0, 1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0,         1'b1, 32'h0000_0000, 32'd0, 4'b0000, 32'h0);
        do_req(0, 1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0000, 32'd0, 4'b0000, 32'h0);
        do_req(0, 1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 32'd0, 4'b0000, 32'h0);

        // Reset during ISSUE of a store: the write still lands, no response follows.
        @(negedge clock);
        req_write = 1'b1;
        req_size = 2'd2;
        req_unsigned = 1'b0;
        req_addr = 32'h0000_0014;
        req_wdata = 32'hCAFE_F00D;
        req_valid[0] = 1'b1;
        sq.push_back('{dut: 0, wr: 1'b1, addr: 32'd5, be: 4'b1111, wdata: 32'hCAFE_F00D});
        @(negedge clock);
        req_valid[0] = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0 || mem_read[0] !== 1'b0 || mem_write[0] !== 1'b0
            || mem_address[0] !== 32'h0 || mem_byteenable[0] !== 4'h0 || mem_wdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: ready=%0b rv=%0b rd=%0b wr=%0b addr=%h be=%h wdata=%h, expected all 0",
                     req_ready[0], resp_valid[0], mem_read[0], mem_write[0], mem_address[0], mem_byteenable[0], mem_wdata[0]);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: req_ready=%0b, expected 1", req_ready[0]);
        end
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h0000_0014, 32'h0,         1'b0, 32'hCAFE_F00D, 32'd5, 4'b1111, 32'h0);

        // Window at 0x1000, 16 words.
        do_req(1, 1'b1, 2'd2, 1'b0, 32'h0000_103C, 32'h1234_5678, 1'b0, 32'h0000_0000, 32'd15, 4'b1111, 32'h1234_5678);
        do_req(1, 1'b0, 2'd2, 1'b0, 32'h0000_103C, 32'h0,         1'b0, 32'h1234_5678, 32'd15, 4'b1111, 32'h0);
        do_req(1, 1'b0, 2'd2, 1'b0, 32'h0000_1040, 32'h0,         1'b1, 32'h0000_0000, 32'd0,  4'b0000, 32'h0);
        do_req(1, 1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'd0,  4'b0000, 32'h0);
        do_req(1, 1'b1, 2'd0, 1'b0, 32'h0000_1000, 32'h0000_005A, 1'b0, 32'h0000_0000, 32'd0,  4'b0001, 32'h5A5A_5A5A);
        do_req(1, 1'b0, 2'd0, 1'b1, 32'h0000_1000, 32'h0,         1'b0, 32'h0000_005A, 32'd0,  4'b0001, 32'h0);

        repeat (5) @(negedge clock);
        checks++;
        if (rq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses and %0d strobes outstanding, expected 0", rq.size(), sq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
